// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: op and FSM state encodings shared by the register bank access controller
package reg_bank_pkg;
    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_CLR = 2'b10,
        OP_PRE = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ARB  = 2'b01,
        S_EXEC = 2'b10,
        S_DONE = 2'b11
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int NrOfReq = 4,
    parameter int IdxBits = (NrOfReq > 1) ? $clog2(NrOfReq) : 1
) (
    input  logic [NrOfReq-1:0] req,
    input  logic [IdxBits-1:0] ptr,
    output logic [NrOfReq-1:0] gnt,
    output logic [IdxBits-1:0] idx,
    output logic               any_req
);
    logic [IdxBits-1:0] k;
    logic               found;
    assign any_req = |req;
    always_comb begin
        gnt   = '0;
        idx   = '0;
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < NrOfReq; i++) begin
            k = IdxBits'((int'(ptr) + i) % NrOfReq);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end
endmodule

// File: rtl/reg_bank_access_ctrl.sv
// reg_bank_access_ctrl: round-robin sequencer issuing read/write/clear/preset ops to a register bank
module reg_bank_access_ctrl
    import reg_bank_pkg::*;
#(
    parameter int NrOfReq  = 4,
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Tick,
    input  logic [NrOfReq-1:0]          req,
    input  logic [2*NrOfReq-1:0]        op,
    input  logic [AddrBits*NrOfReq-1:0] addr,
    input  logic [NrOfBits*NrOfReq-1:0] wdata,
    output logic [NrOfReq-1:0]          gnt,
    output logic                        done,
    output logic                        err,
    output logic [NrOfBits-1:0]         rdata,
    output logic [NrOfRegs-1:0]         reg_cs,
    output logic [NrOfRegs-1:0]         reg_ce,
    output logic [NrOfRegs-1:0]         reg_clr,
    output logic [NrOfRegs-1:0]         reg_pre,
    output logic [NrOfBits-1:0]         reg_d,
    input  logic [NrOfBits-1:0]         bus_q
);
    localparam int IdxBits = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

    state_e                state, state_nx;
    op_e                   op_q, sel_op;
    logic                  bad_q, sel_bad, any_req, launch, finish;
    logic [IdxBits-1:0]    ptr, idx_q, arb_idx;
    logic [NrOfReq-1:0]    arb_gnt;
    logic [AddrBits-1:0]   sel_addr;
    logic [NrOfBits-1:0]   sel_wdata;
    logic [NrOfRegs-1:0]   dec;

    rr_arbiter #(.NrOfReq(NrOfReq), .IdxBits(IdxBits)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .any_req (any_req)
    );

    assign sel_op    = op_e'(op[int'(arb_idx)*2 +: 2]);
    assign sel_addr  = addr[int'(arb_idx)*AddrBits +: AddrBits];
    assign sel_wdata = wdata[int'(arb_idx)*NrOfBits +: NrOfBits];
    assign sel_bad   = 32'(sel_addr) >= NrOfRegs;
    // strobes are decoded from the live winner so they appear on the flop outputs in the first EXEC cycle
    assign dec       = sel_bad ? '0 : NrOfRegs'(1) << sel_addr;
    assign launch    = (state == S_ARB) && any_req;
    assign finish    = (state == S_EXEC) && (state_nx == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = |req ? S_ARB : S_IDLE;
            S_ARB:   state_nx = any_req ? S_EXEC : S_IDLE;
            S_EXEC:  state_nx = (bad_q || op_q != OP_WR || Tick) ? S_DONE : S_EXEC;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            op_q    <= OP_RD;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            ptr     <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            reg_cs  <= '1;
            reg_ce  <= '0;
            reg_clr <= '0;
            reg_pre <= '0;
            reg_d   <= '0;
        end else begin
            state <= state_nx;
            done  <= state_nx == S_DONE;
            err   <= (state_nx == S_DONE) && bad_q;
            if (launch) begin
                gnt     <= arb_gnt;
                idx_q   <= arb_idx;
                op_q    <= sel_op;
                bad_q   <= sel_bad;
                reg_cs  <= (sel_op == OP_RD)  ? ~dec : '1;
                reg_ce  <= (sel_op == OP_WR)  ? dec : '0;
                reg_clr <= (sel_op == OP_CLR) ? dec : '0;
                reg_pre <= (sel_op == OP_PRE) ? dec : '0;
                if (sel_op == OP_WR && !sel_bad) reg_d <= sel_wdata;
            end
            if (finish) begin
                reg_cs  <= '1;
                reg_ce  <= '0;
                reg_clr <= '0;
                reg_pre <= '0;
                if (op_q == OP_RD && !bad_q) rdata <= bus_q;
            end
            if (state == S_DONE) begin
                gnt <= '0;
                ptr <= (32'(idx_q) == NrOfReq - 1) ? '0 : idx_q + IdxBits'(1);
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_access_ctrl.sv
// tb_reg_bank_access_ctrl: directed checks of arbitration, op sequencing, errors and reset
module tb_reg_bank_access_ctrl;
    logic        Clock = 1'b0;
    logic        Reset, Tick;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [7:0]  bus_q;
    logic [3:0]  gnt, b_gnt;
    logic        done, err, b_done, b_err;
    logic [7:0]  rdata, reg_d, b_rdata, b_reg_d;
    logic [7:0]  reg_cs, reg_ce, reg_clr, reg_pre;
    logic [5:0]  b_reg_cs, b_reg_ce, b_reg_clr, b_reg_pre;
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    reg_bank_access_ctrl #(.NrOfReq(4), .NrOfRegs(8), .AddrBits(3), .NrOfBits(8)) u_dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .reg_cs(reg_cs), .reg_ce(reg_ce),
        .reg_clr(reg_clr), .reg_pre(reg_pre), .reg_d(reg_d), .bus_q(bus_q)
    );

    // smaller bank so address 7 is out of range
    reg_bank_access_ctrl #(.NrOfReq(4), .NrOfRegs(6), .AddrBits(3), .NrOfBits(8)) u_b (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(b_gnt), .done(b_done), .err(b_err), .rdata(b_rdata), .reg_cs(b_reg_cs), .reg_ce(b_reg_ce),
        .reg_clr(b_reg_clr), .reg_pre(b_reg_pre), .reg_d(b_reg_d), .bus_q(bus_q)
    );

    task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
        op[2*i +: 2]    = o;
        addr[3*i +: 3]  = a;
        wdata[8*i +: 8] = d;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Tick = 1'b0; req = '0; op = '0; addr = '0; wdata = '0; bus_q = '0;
        repeat (3) @(negedge Clock);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_done_err got %b want 00", {done, err}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rdata); end
        checks++; if (reg_cs !== 8'hFF) begin errors++; $display("FAIL rst_cs got %b want 11111111", reg_cs); end
        checks++; if ({reg_ce, reg_clr, reg_pre, reg_d} !== 32'h0) begin errors++; $display("FAIL rst_strobes got %h want 0", {reg_ce, reg_clr, reg_pre, reg_d}); end
        checks++; if (b_reg_cs !== 6'h3F) begin errors++; $display("FAIL rst_b_cs got %b want 111111", b_reg_cs); end
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if ({gnt, done} !== 5'b0) begin errors++; $display("FAIL rst_idle got %b want 00000", {gnt, done}); end
    endtask

    task automatic test_read;
        set_req(0, 2'b00, 3'd2, 8'h00);
        bus_q = 8'hA5; req = 4'b0001;
        @(negedge Clock);
        checks++; if ({gnt, done} !== 5'b0) begin errors++; $display("FAIL rd_arb got %b want 00000", {gnt, done}); end
        @(negedge Clock);
        checks++; if (reg_cs !== 8'hFB) begin errors++; $display("FAIL rd_cs got %b want 11111011", reg_cs); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt got %b want 0001", gnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_early_done got %b want 0", done); end
        @(negedge Clock);
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL rd_done got %b want 10", {done, err}); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got %h want a5", rdata); end
        checks++; if (reg_cs !== 8'hFF) begin errors++; $display("FAIL rd_cs_release got %b want 11111111", reg_cs); end
        checks++; if (b_rdata !== 8'hA5) begin errors++; $display("FAIL rd_b_rdata got %h want a5", b_rdata); end
        req = 4'b0000;
        @(negedge Clock);
        checks++; if ({gnt, done} !== 5'b0) begin errors++; $display("FAIL rd_after got %b want 00000", {gnt, done}); end
    endtask

    task automatic test_write_stall;
        set_req(1, 2'b01, 3'd5, 8'h3C);
        Tick = 1'b0; bus_q = 8'h00; req = 4'b0010;
        @(negedge Clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clock);
            checks++; if (reg_ce !== 8'h20) begin errors++; $display("FAIL wr_ce cyc %0d got %b want 00100000", k, reg_ce); end
            checks++; if ({done, gnt} !== 5'b00010) begin errors++; $display("FAIL wr_stall cyc %0d got %b want 00010", k, {done, gnt}); end
            if (k == 1) begin
                checks++; if (reg_d !== 8'h3C) begin errors++; $display("FAIL wr_d got %h want 3c", reg_d); end
            end
            if (k == 5) Tick = 1'b1;
        end
        @(negedge Clock);
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL wr_done got %b want 10", {done, err}); end
        checks++; if (reg_ce !== 8'h00) begin errors++; $display("FAIL wr_ce_release got %b want 0", reg_ce); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_kept got %h want a5", rdata); end
        Tick = 1'b0; req = 4'b0000;
        @(negedge Clock);
    endtask

    task automatic test_round_robin;
        int exp [5] = '{0, 1, 2, 3, 0};
        Reset = 1'b1; req = '0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 3'(i), 8'h00);
        bus_q = 8'h77; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int n = 0;
            logic [7:0] cs_seen = 8'hFF;
            logic [3:0] eg = 4'(1 << exp[g]);
            logic [7:0] ec = ~8'(1 << exp[g]);
            do begin
                @(negedge Clock);
                n++;
                if (gnt !== 4'b0 && done !== 1'b1) cs_seen = reg_cs;
            end while (done !== 1'b1 && n < 10);
            checks++; if (n >= 10) begin errors++; $display("FAIL rr_timeout grant %0d got %0d cycles want <10", g, n); end
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt grant %0d got %b want %b", g, gnt, eg); end
            checks++; if (cs_seen !== ec) begin errors++; $display("FAIL rr_cs grant %0d got %b want %b", g, cs_seen, ec); end
        end
        req = 4'b0000;
        @(negedge Clock);
        checks++; if (b_rdata !== 8'h77) begin errors++; $display("FAIL rr_b_rdata got %h want 77", b_rdata); end
    endtask

    task automatic test_clear_preset;
        int n = 0, dn = 0, cn = 0, pn = 0, ov = 0, bx = 0, bm = 0;
        set_req(0, 2'b10, 3'd7, 8'h00);
        req = 4'b0001;
        while (dn < 2 && n < 20) begin
            @(negedge Clock);
            n++;
            if (reg_clr[7]) cn++;
            if (reg_pre[7]) pn++;
            if ($countones({~reg_cs, reg_ce, reg_clr, reg_pre}) > 1 || reg_clr[6:0] != 0 || reg_pre[6:0] != 0) ov++;
            if (|{~b_reg_cs, b_reg_ce, b_reg_clr, b_reg_pre}) bx++;
            if (done) begin
                dn++;
                if (b_err !== 1'b1 || err !== 1'b0) bm++;
                if (dn == 1) op[1:0] = 2'b11;
                else req = 4'b0000;
            end
        end
        checks++; if (dn != 2) begin errors++; $display("FAIL cp_dones got %0d want 2", dn); end
        checks++; if (cn != 1) begin errors++; $display("FAIL cp_clr_cycles got %0d want 1", cn); end
        checks++; if (pn != 1) begin errors++; $display("FAIL cp_pre_cycles got %0d want 1", pn); end
        checks++; if (ov != 0) begin errors++; $display("FAIL cp_overlap got %0d want 0", ov); end
        checks++; if (bx != 0) begin errors++; $display("FAIL cp_b_lines got %0d want 0", bx); end
        checks++; if (bm != 0) begin errors++; $display("FAIL cp_err_flags got %0d want 0", bm); end
        @(negedge Clock);
    endtask

    task automatic test_bad_addr;
        int n = 0, bx = 0;
        set_req(0, 2'b00, 3'd7, 8'h00);
        bus_q = 8'h5A; req = 4'b0001;
        do begin
            @(negedge Clock);
            n++;
            if (|{~b_reg_cs, b_reg_ce, b_reg_clr, b_reg_pre}) bx++;
        end while (b_done !== 1'b1 && n < 10);
        checks++; if (n != 3) begin errors++; $display("FAIL bad_latency got %0d want 3", n); end
        checks++; if ({b_done, b_err} !== 2'b11) begin errors++; $display("FAIL bad_err got %b want 11", {b_done, b_err}); end
        checks++; if (b_rdata !== 8'h77) begin errors++; $display("FAIL bad_rdata got %h want 77", b_rdata); end
        checks++; if (bx != 0) begin errors++; $display("FAIL bad_lines got %0d want 0", bx); end
        checks++; if ({done, err, rdata} !== 10'b10_0101_1010) begin errors++; $display("FAIL bad_ref_read got %b want 1001011010", {done, err, rdata}); end
        req = 4'b0000;
        @(negedge Clock);
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b want 0", b_err); end
    endtask

    task automatic test_req_drop;
        set_req(3, 2'b00, 3'd4, 8'h00);
        bus_q = 8'hC3; req = 4'b1000;
        repeat (2) @(negedge Clock);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_gnt got %b want 1000", gnt); end
        checks++; if (reg_cs !== 8'hEF) begin errors++; $display("FAIL drop_cs got %b want 11101111", reg_cs); end
        req = 4'b0000;
        @(negedge Clock);
        checks++; if ({done, gnt} !== 5'b11000) begin errors++; $display("FAIL drop_done got %b want 11000", {done, gnt}); end
        checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL drop_rdata got %h want c3", rdata); end
        @(negedge Clock);
        checks++; if ({done, gnt} !== 5'b0) begin errors++; $display("FAIL drop_after got %b want 00000", {done, gnt}); end
    endtask

    task automatic test_reset_mid_write;
        int dn = 0;
        set_req(2, 2'b01, 3'd3, 8'h99);
        Tick = 1'b0; req = 4'b0100;
        repeat (2) @(negedge Clock);
        checks++; if ({gnt, reg_ce} !== 12'b0100_0000_1000) begin errors++; $display("FAIL mid_exec got %b want 010000001000", {gnt, reg_ce}); end
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL mid_gnt got %b want 0000", gnt); end
        checks++; if (reg_ce !== 8'h00 || reg_cs !== 8'hFF) begin errors++; $display("FAIL mid_lines got ce %b cs %b want 0 and ff", reg_ce, reg_cs); end
        checks++; if ({done, reg_d} !== 9'h0) begin errors++; $display("FAIL mid_done_d got %b want 0", {done, reg_d}); end
        Reset = 1'b0; req = 4'b0000;
        repeat (6) begin
            @(negedge Clock);
            if (done) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", dn); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_stall;
        test_round_robin;
        test_clear_preset;
        test_bad_addr;
        test_req_drop;
        test_reset_mid_write;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
